// File: rtl/light_sense_if.sv
// Signal bundle between the light-sensing block and its consumer:
// raw sensor bits and enables in, debounced per-channel state and pulses out.
interface light_sense_if #(
   parameter int CHANNELS = 4
);
   localparam int LC_W = $clog2(CHANNELS + 1);

   logic [CHANNELS-1:0] sensor_input;
   logic [CHANNELS-1:0] ch_enable;
   logic [CHANNELS-1:0] light_detected;
   logic [CHANNELS-1:0] light_rise;
   logic [CHANNELS-1:0] light_fall;
   logic                any_light;
   logic [LC_W-1:0]     light_count;

   modport master (
      output sensor_input, ch_enable,
      input  light_detected, light_rise, light_fall, any_light, light_count
   );

   modport slave (
      input  sensor_input, ch_enable,
      output light_detected, light_rise, light_fall, any_light, light_count
   );
endinterface

// File: rtl/light_sense.sv
// Multi-channel LDR light detector: per-channel two-flop synchroniser followed by
// a debounce FSM producing a registered light state plus rise/fall pulses.
module light_sense #(
   parameter int CHANNELS        = 4,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int INVERT          = 0
) (
   input logic           clk,
   input logic           reset,
   light_sense_if.slave  bus
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam int LC_W  = $clog2(CHANNELS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      DARK       = 2'd0,
      PEND_LIGHT = 2'd1,
      LIT        = 2'd2,
      PEND_DARK  = 2'd3
   } state_t;

   logic [CHANNELS-1:0] raw;
   logic [CHANNELS-1:0] sync_meta;
   logic [CHANNELS-1:0] sync_s;

   state_t [CHANNELS-1:0]            state;
   logic   [CHANNELS-1:0][CNT_W-1:0] cnt;
   logic   [CHANNELS-1:0]            detected_q;
   logic   [CHANNELS-1:0]            rise_q;
   logic   [CHANNELS-1:0]            fall_q;
   logic   [LC_W-1:0]                count_sum;

   assign raw = (INVERT != 0) ? ~bus.sensor_input : bus.sensor_input;

   // Synchroniser keeps sampling even for disabled channels.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_meta <= '0;
         sync_s    <= '0;
      end else begin
         // NOTE: non-blocking here so sync_s takes the old sync_meta; blocking would collapse the two stages.
         sync_meta <= raw;
         sync_s    <= sync_meta;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: these per-channel arrays are plain flops, not RAM, so they take the async clear like any register.
         for (int i = 0; i < CHANNELS; i++) begin
            state[i] <= DARK;
            cnt[i]   <= '0;
         end
         detected_q <= '0;
         rise_q     <= '0;
         fall_q     <= '0;
      end else begin
         rise_q <= '0;
         fall_q <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            if (!bus.ch_enable[i]) begin
               // Disable wins over debouncing; a lit channel reports its drop.
               state[i]      <= DARK;
               cnt[i]        <= '0;
               detected_q[i] <= 1'b0;
               fall_q[i]     <= detected_q[i];
            end else begin
               unique case (state[i])
                  DARK: begin
                     if (sync_s[i]) begin
                        state[i] <= PEND_LIGHT;
                        cnt[i]   <= CNT_ONE;
                     end else begin
                        cnt[i]   <= '0;
                     end
                  end
                  PEND_LIGHT: begin
                     if (!sync_s[i]) begin
                        state[i] <= DARK;
                        cnt[i]   <= '0;
                     end else if (cnt[i] == CNT_LAST) begin
                        state[i]      <= LIT;
                        detected_q[i] <= 1'b1;
                        rise_q[i]     <= 1'b1;
                        cnt[i]        <= '0;
                     end else begin
                        cnt[i]   <= cnt[i] + CNT_ONE;
                     end
                  end
                  LIT: begin
                     if (!sync_s[i]) begin
                        state[i] <= PEND_DARK;
                        cnt[i]   <= CNT_ONE;
                     end else begin
                        cnt[i]   <= '0;
                     end
                  end
                  PEND_DARK: begin
                     if (sync_s[i]) begin
                        state[i] <= LIT;
                        cnt[i]   <= '0;
                     end else if (cnt[i] == CNT_LAST) begin
                        state[i]      <= DARK;
                        detected_q[i] <= 1'b0;
                        fall_q[i]     <= 1'b1;
                        cnt[i]        <= '0;
                     end else begin
                        cnt[i]   <= cnt[i] + CNT_ONE;
                     end
                  end
               endcase
            end
         end
      end
   end

   always_comb begin
      // NOTE: default assigned first so the loop never leaves count_sum unassigned (no latch).
      count_sum = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         count_sum = count_sum + LC_W'(detected_q[i]);
      end
   end

   assign bus.light_detected = detected_q;
   assign bus.light_rise     = rise_q;
   assign bus.light_fall     = fall_q;
   assign bus.any_light      = |detected_q;
   assign bus.light_count    = count_sum;

endmodule

// File: tb/tb_light_sense.sv
// Bench for light_sense: one normal-polarity and one inverted instance checked
// every cycle against a behavioural debounce model, plus directed literal checks.
module tb_light_sense;

   localparam int CH = 4;
   localparam int D  = 4;

   logic clk;
   logic reset = 1'b0;
   bit   run_checks = 1'b0;
   int   checks = 0;
   int   errors = 0;

   light_sense_if #(.CHANNELS(CH)) ia ();
   light_sense_if #(.CHANNELS(CH)) ib ();

   light_sense #(.CHANNELS(CH), .DEBOUNCE_CYCLES(D), .INVERT(0)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ia)
   );

   light_sense #(.CHANNELS(CH), .DEBOUNCE_CYCLES(D), .INVERT(1)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ib)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 30)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a channel flips once the level it sees (two clocks after the pin)
   // has disagreed with its current state for D consecutive clocks.
   logic [CH-1:0] m_lit [2];
   logic [CH-1:0] m_rise[2];
   logic [CH-1:0] m_fall[2];
   logic [CH-1:0] m_p0  [2];
   logic [CH-1:0] m_p1  [2];
   int            m_run [2][CH];

   task automatic model_clear(input int u);
      m_lit[u] = '0; m_rise[u] = '0; m_fall[u] = '0;
      m_p0[u]  = '0; m_p1[u]   = '0;
      for (int c = 0; c < CH; c++) m_run[u][c] = 0;
   endtask

   task automatic model_edge(input int u, input logic [CH-1:0] level, input logic [CH-1:0] en);
      logic [CH-1:0] s;
      s        = m_p1[u];
      m_p1[u]  = m_p0[u];
      m_p0[u]  = level;
      m_rise[u] = '0;
      m_fall[u] = '0;
      for (int c = 0; c < CH; c++) begin
         if (!en[c]) begin
            if (m_lit[u][c]) m_fall[u][c] = 1'b1;
            m_lit[u][c] = 1'b0;
            m_run[u][c] = 0;
         end else if (s[c] != m_lit[u][c]) begin
            m_run[u][c]++;
            if (m_run[u][c] == D) begin
               m_lit[u][c] = s[c];
               if (s[c]) m_rise[u][c] = 1'b1;
               else      m_fall[u][c] = 1'b1;
               m_run[u][c] = 0;
            end
         end else begin
            m_run[u][c] = 0;
         end
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         model_clear(0);
         model_clear(1);
      end else begin
         model_edge(0, ia.sensor_input, ia.ch_enable);
         model_edge(1, ~ib.sensor_input, ib.ch_enable);
      end
   end

   // Cycle-by-cycle comparison, sampled mid-period.
   initial begin
      wait (run_checks);
      forever begin
         @(negedge clk);
         check("a_detected", ia.light_detected, m_lit[0]);
         check("a_rise",     ia.light_rise,     m_rise[0]);
         check("a_fall",     ia.light_fall,     m_fall[0]);
         check("a_any",      ia.any_light,      |m_lit[0]);
         check("a_count",    ia.light_count,    $countones(m_lit[0]));
         check("b_detected", ib.light_detected, m_lit[1]);
         check("b_rise",     ib.light_rise,     m_rise[1]);
         check("b_fall",     ib.light_fall,     m_fall[1]);
         check("b_any",      ib.any_light,      |m_lit[1]);
         check("b_count",    ib.light_count,    $countones(m_lit[1]));
      end
   end

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      ia.sensor_input = '0; ia.ch_enable = '1;
      ib.sensor_input = '0; ib.ch_enable = '1;
      edges(3);
      run_checks = 1'b1;
      check("reset_a_det",   ia.light_detected, 4'h0);
      check("reset_a_count", ia.light_count,    3'd0);
      check("reset_a_any",   ia.any_light,      1'b0);
      check("reset_b_det",   ib.light_detected, 4'h0);

      // Inverted instance: pins low from reset means light on every channel.
      reset = 1'b1;
      edges(5);
      check("inv_not_yet",   ib.light_detected, 4'h0);
      edges(1);
      check("inv_lit",       ib.light_detected, 4'hF);
      check("inv_rise",      ib.light_rise,     4'hF);
      check("inv_count",     ib.light_count,    3'd4);
      ib.sensor_input = 4'hF;
      edges(5);
      check("inv_still_lit", ib.light_detected, 4'hF);
      edges(1);
      check("inv_dark",      ib.light_detected, 4'h0);
      check("inv_fall",      ib.light_fall,     4'hF);

      // Single channel lights at k+5.
      ia.sensor_input = 4'b0001;
      edges(5);
      check("ch0_not_yet",   ia.light_detected, 4'h0);
      edges(1);
      check("ch0_lit",       ia.light_detected, 4'b0001);
      check("ch0_rise",      ia.light_rise,     4'b0001);
      check("ch0_count",     ia.light_count,    3'd1);
      check("ch0_any",       ia.any_light,      1'b1);
      edges(1);
      check("ch0_rise_once", ia.light_rise,     4'h0);

      // Two-cycle dropout is absorbed.
      ia.sensor_input = 4'b0000;
      edges(2);
      ia.sensor_input = 4'b0001;
      edges(8);
      check("glitch_kept",   ia.light_detected, 4'b0001);

      // Held low: falls at k+5.
      ia.sensor_input = 4'b0000;
      edges(5);
      check("ch0_still_lit", ia.light_detected, 4'b0001);
      edges(1);
      check("ch0_dark",      ia.light_detected, 4'b0000);
      check("ch0_fall",      ia.light_fall,     4'b0001);
      edges(1);
      check("ch0_fall_once", ia.light_fall,     4'h0);

      // All channels together.
      ia.sensor_input = 4'hF;
      edges(5);
      check("all_not_yet",   ia.light_detected, 4'h0);
      edges(1);
      check("all_lit",       ia.light_detected, 4'hF);
      check("all_rise",      ia.light_rise,     4'hF);
      check("all_count",     ia.light_count,    3'd4);

      // Disable ch2 while lit, then re-enable with light present.
      edges(2);
      ia.ch_enable = 4'b1011;
      edges(1);
      check("dis_det",       ia.light_detected, 4'b1011);
      check("dis_fall",      ia.light_fall,     4'b0100);
      check("dis_count",     ia.light_count,    3'd3);
      edges(1);
      check("dis_fall_once", ia.light_fall,     4'h0);
      ia.ch_enable = 4'hF;
      edges(3);
      check("reen_not_yet",  ia.light_detected, 4'b1011);
      edges(1);
      check("reen_lit",      ia.light_detected, 4'hF);
      check("reen_rise",     ia.light_rise,     4'b0100);

      // Reset in the middle of a pending rise.
      ia.sensor_input = 4'h0;
      edges(8);
      check("pre_rst_dark",  ia.light_detected, 4'h0);
      ia.sensor_input = 4'b0001;
      edges(4);
      reset = 1'b0;
      #1;
      check("rst_det",       ia.light_detected, 4'h0);
      check("rst_rise",      ia.light_rise,     4'h0);
      check("rst_count",     ia.light_count,    3'd0);
      edges(2);
      reset = 1'b1;
      edges(5);
      check("post_rst_wait", ia.light_detected, 4'h0);
      edges(1);
      check("post_rst_lit",  ia.light_detected, 4'b0001);
      check("post_rst_rise", ia.light_rise,     4'b0001);
      edges(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
